pnr_discriminator: RTL and testbench

Parametrised photon-number-resolving discriminator for the ADC_CLK domain. It opens a measurement window on `trigger` and closes it on the rising edge of `delayed_trigger`. In the chosen mode it evaluates either the instantaneous sample or the peak held over the window, and compares that value against NLEV signed thresholds. It drives a one-hot photon-number vector (for extension GPIO), a binary count, a one-cycle result strobe and sticky error flags. Fully synchronous: `delayed_trigger` is a data input, never a clock.

---
 rtl/pnr_discriminator.sv | 188 ++++++++++++++++++
 tb/tb_pnr_discriminator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pnr_discriminator.sv
// Photon-number-resolving discriminator: windows the ADC sample stream between trigger and the
// rising edge of delayed_trigger, then bins the sample (or window peak) against NLEV thresholds.
module pnr_discriminator #(
    parameter int DW      = 14,
    parameter int NLEV    = 8,
    parameter int CW      = 4,
    parameter int MAX_WIN = 1024
) (
    input  logic                   ADC_CLK,
    input  logic                   rstn_i,
    input  logic                   trigger,
    input  logic                   delayed_trigger,
    input  logic signed [DW-1:0]   pnr_source_sig,
    input  logic [NLEV*DW-1:0]     thresholds,
    input  logic                   peak_mode,
    input  logic                   clr_err,
    output logic [NLEV:0]          photon_onehot,
    output logic [CW-1:0]          photon_num,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   err_orphan,
    output logic                   err_timeout,
    output logic [31:0]            result_cnt
);

    localparam int WCW = $clog2(MAX_WIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WINDOW,
        S_EVAL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic signed [DW-1:0]  r_sample_q;
    logic                  r_dt_q;
    logic signed [DW-1:0]  r_peak;
    logic signed [DW-1:0]  r_eval_val;
    logic [WCW-1:0]        r_win_cnt;
    logic [NLEV:0]         r_onehot;
    logic [CW-1:0]         r_num;
    logic                  r_valid;
    logic                  r_err_orphan;
    logic                  r_err_timeout;
    logic [31:0]           r_result_cnt;

    logic                  w_ce;
    logic                  w_open;
    logic                  w_close;
    logic                  w_timeout;
    logic                  w_orphan;
    logic                  w_eval;
    logic signed [DW-1:0]  w_peak_max;
    logic signed [DW-1:0]  w_thr [NLEV];
    logic [CW-1:0]         w_count;
    logic [NLEV:0]         w_onehot;

    // Close request is an edge on a plain data input; the previous level lives in r_dt_q.
    assign w_ce       = delayed_trigger & ~r_dt_q;
    assign w_peak_max = (r_sample_q > r_peak) ? r_sample_q : r_peak;

    for (genvar g = 0; g < NLEV; g++) begin : g_thr
        assign w_thr[g] = $signed(thresholds[g*DW +: DW]);
    end

    // Count-based binning keeps the result one-hot even if thresholds are out of order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_count = '0;
        for (int i = 0; i < NLEV; i++) begin
            if (w_thr[i] < r_eval_val) begin
                w_count = w_count + CW'(1);
            end
        end
        w_onehot = (NLEV + 1)'(1) << w_count;
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state is always updated with non-blocking assignments.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_open      = 1'b0;
        w_close     = 1'b0;
        w_timeout   = 1'b0;
        w_orphan    = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_open      = 1'b1;
                    w_state_nxt = S_WINDOW;
                end else if (w_ce) begin
                    w_orphan = 1'b1;
                end
            end
            S_WINDOW: begin
                // Close beats a coincident re-trigger; timeout only when neither arrives.
                if (w_ce) begin
                    w_close     = 1'b1;
                    w_state_nxt = S_EVAL;
                end else if (trigger) begin
                    w_open = 1'b1;
                end else if (r_win_cnt == WCW'(MAX_WIN - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sample_q <= '0;
            r_dt_q     <= 1'b0;
            r_peak     <= '0;
            r_win_cnt  <= '0;
            r_eval_val <= '0;
        end else begin
            r_sample_q <= pnr_source_sig;
            r_dt_q     <= delayed_trigger;
            if (w_open) begin
                r_peak    <= r_sample_q;
                r_win_cnt <= '0;
            end else if (r_state == S_WINDOW) begin
                r_peak    <= w_peak_max;
                r_win_cnt <= r_win_cnt + WCW'(1);
            end
            if (w_close) begin
                r_eval_val <= peak_mode ? w_peak_max : r_sample_q;
            end
        end
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_onehot     <= '0;
            r_num        <= '0;
            r_valid      <= 1'b0;
            r_result_cnt <= '0;
        end else begin
            r_valid <= w_eval;
            if (w_eval) begin
                r_onehot     <= w_onehot;
                r_num        <= w_count;
                r_result_cnt <= r_result_cnt + 32'd1;
            end else if (w_open) begin
                r_onehot <= '0;
                r_num    <= '0;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err_orphan  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_orphan  <= w_orphan  | (r_err_orphan  & ~clr_err);
            r_err_timeout <= w_timeout | (r_err_timeout & ~clr_err);
        end
    end

    assign photon_onehot = r_onehot;
    assign photon_num    = r_num;
    assign result_valid  = r_valid;
    assign busy          = (r_state != S_IDLE);
    assign err_orphan    = r_err_orphan;
    assign err_timeout   = r_err_timeout;
    assign result_cnt    = r_result_cnt;

endmodule

// File: tb/tb_pnr_discriminator.sv
// Directed bench for pnr_discriminator: thresholds 100..800, MAX_WIN=16, hand-computed results.
module tb_pnr_discriminator;

    localparam int DW      = 14;
    localparam int NLEV    = 8;
    localparam int CW      = 4;
    localparam int MAX_WIN = 16;

    logic                  ADC_CLK = 1'b0;
    logic                  rstn_i;
    logic                  trigger;
    logic                  delayed_trigger;
    logic signed [DW-1:0]  pnr_source_sig;
    logic [NLEV*DW-1:0]    thresholds;
    logic                  peak_mode;
    logic                  clr_err;
    logic [NLEV:0]         photon_onehot;
    logic [CW-1:0]         photon_num;
    logic                  result_valid;
    logic                  busy;
    logic                  err_orphan;
    logic                  err_timeout;
    logic [31:0]           result_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic signed [DW-1:0] wave [6];

    pnr_discriminator #(
        .DW      (DW),
        .NLEV    (NLEV),
        .CW      (CW),
        .MAX_WIN (MAX_WIN)
    ) dut (
        .ADC_CLK         (ADC_CLK),
        .rstn_i          (rstn_i),
        .trigger         (trigger),
        .delayed_trigger (delayed_trigger),
        .pnr_source_sig  (pnr_source_sig),
        .thresholds      (thresholds),
        .peak_mode       (peak_mode),
        .clr_err         (clr_err),
        .photon_onehot   (photon_onehot),
        .photon_num      (photon_num),
        .result_valid    (result_valid),
        .busy            (busy),
        .err_orphan      (err_orphan),
        .err_timeout     (err_timeout),
        .result_cnt      (result_cnt)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge ADC_CLK);
        #1;
    endtask

    task automatic fill(input int a, input int b, input int c, input int d, input int e, input int f);
        wave[0] = DW'(a); wave[1] = DW'(b); wave[2] = DW'(c);
        wave[3] = DW'(d); wave[4] = DW'(e); wave[5] = DW'(f);
    endtask

    // One full measurement: trigger, five window samples, close edge, evaluate.
    task automatic run_meas(input string tag, input logic mode, input int exp_num);
        peak_mode      = mode;
        pnr_source_sig = wave[0];
        tick(1);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        check({tag, "_busy_open"}, 32'(busy), 32'd1);
        check({tag, "_cleared"}, {23'd0, photon_onehot}, 32'd0);
        for (int i = 1; i < 6; i++) begin
            pnr_source_sig = wave[i];
            tick(1);
        end
        delayed_trigger = 1'b1;
        tick(1);
        check({tag, "_no_early_valid"}, 32'(result_valid), 32'd0);
        tick(1);
        exp_cnt++;
        check({tag, "_num"}, 32'(photon_num), 32'(exp_num));
        check({tag, "_onehot"}, {23'd0, photon_onehot}, 32'd1 << exp_num);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_cnt"}, result_cnt, 32'(exp_cnt));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        delayed_trigger = 1'b0;
        tick(1);
        check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        check({tag, "_hold"}, 32'(photon_num), 32'(exp_num));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i          = 1'b0;
        trigger         = 1'b0;
        delayed_trigger = 1'b0;
        pnr_source_sig  = '0;
        peak_mode       = 1'b0;
        clr_err         = 1'b0;
        for (int i = 0; i < NLEV; i++) thresholds[i*DW +: DW] = DW'(100 * (i + 1));
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_onehot", {23'd0, photon_onehot}, 32'd0);
        check("rst_errs", {30'd0, err_orphan, err_timeout}, 32'd0);
        check("rst_cnt", result_cnt, 32'd0);
        rstn_i = 1'b1;
        tick(2);

        fill(350, 350, 350, 350, 350, 350);
        run_meas("sample_350", 1'b0, 3);
        fill(50, 300, 720, 400, 100, 50);
        run_meas("peak_pulse", 1'b1, 7);
        run_meas("sample_pulse", 1'b0, 0);
        fill(900, 900, 900, 900, 900, 900);
        run_meas("above_all", 1'b0, 8);
        fill(100, 100, 100, 100, 100, 100);
        run_meas("equal_thr1", 1'b0, 0);
        fill(-300, -300, -300, -300, -300, -300);
        run_meas("negative", 1'b1, 0);

        // Orphan close edge in IDLE, then clear, then set-beats-clear.
        delayed_trigger = 1'b1;
        tick(1);
        check("orphan_set", 32'(err_orphan), 32'd1);
        check("orphan_no_valid", 32'(result_valid), 32'd0);
        check("orphan_idle", 32'(busy), 32'd0);
        delayed_trigger = 1'b0;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("orphan_clr", 32'(err_orphan), 32'd0);
        delayed_trigger = 1'b1;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        delayed_trigger = 1'b0;
        check("orphan_set_wins", 32'(err_orphan), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;

        // Trigger and close edge together in IDLE: window opens, no error.
        pnr_source_sig  = DW'(350);
        peak_mode       = 1'b0;
        trigger         = 1'b1;
        delayed_trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        check("trig_ce_busy", 32'(busy), 32'd1);
        check("trig_ce_no_err", 32'(err_orphan), 32'd0);
        tick(1);
        delayed_trigger = 1'b0;
        tick(1);
        delayed_trigger = 1'b1;
        tick(2);
        exp_cnt++;
        check("trig_ce_num", 32'(photon_num), 32'd3);
        check("trig_ce_cnt", result_cnt, 32'(exp_cnt));
        delayed_trigger = 1'b0;
        tick(1);

        // Timeout: entry at edge j, flag and IDLE at edge j+MAX_WIN.
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(MAX_WIN - 1);
        check("to_busy_before", 32'(busy), 32'd1);
        check("to_flag_before", 32'(err_timeout), 32'd0);
        tick(1);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_flag_after", 32'(err_timeout), 32'd1);
        check("to_outputs", {19'd0, photon_onehot, photon_num}, 32'd0);
        check("to_no_valid", 32'(result_valid), 32'd0);
        check("to_cnt", result_cnt, 32'(exp_cnt));
        delayed_trigger = 1'b1;
        tick(1);
        delayed_trigger = 1'b0;
        check("to_late_orphan", 32'(err_orphan), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("to_clr", {30'd0, err_orphan, err_timeout}, 32'd0);

        // Re-trigger mid-window drops the earlier 800 spike from the peak.
        peak_mode      = 1'b1;
        pnr_source_sig = DW'(50);
        tick(1);
        trigger = 1'b1;
        tick(1);
        trigger        = 1'b0;
        pnr_source_sig = DW'(800);
        tick(1);
        pnr_source_sig = DW'(50);
        tick(1);
        trigger        = 1'b1;
        pnr_source_sig = DW'(350);
        tick(1);
        trigger = 1'b0;
        tick(2);
        delayed_trigger = 1'b1;
        tick(2);
        exp_cnt++;
        check("retrig_num", 32'(photon_num), 32'd3);
        check("retrig_valid", 32'(result_valid), 32'd1);
        check("retrig_no_err", 32'(err_orphan), 32'd0);
        delayed_trigger = 1'b0;
        tick(1);

        // Async reset mid-window with a sticky flag set beforehand.
        delayed_trigger = 1'b1;
        tick(1);
        delayed_trigger = 1'b0;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(2);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_outputs", {19'd0, photon_onehot, photon_num}, 32'd0);
        check("arst_errs", {30'd0, err_orphan, err_timeout}, 32'd0);
        check("arst_cnt", result_cnt, 32'd0);
        @(posedge ADC_CLK);
        #2;
        rstn_i = 1'b1;
        exp_cnt = 0;
        tick(6);
        check("arst_no_valid", 32'(result_valid), 32'd0);
        check("arst_cnt_after", result_cnt, 32'(exp_cnt));
        check("arst_idle_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
